color_duty_ctrl: RTL and testbench
==================================

COLOR_DUTY_CTRL -- requirements
Module: color_duty_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, shall set the number of consecutive cycles a synchronized button level must differ from its stable value before it is accepted (10 ms at 25 MHz).
REQ-002 Parameter DUTY_STEP, default 10, shall set the dutyValue increment/decrement per accepted press.
REQ-003 Parameter DUTY_MAX, default 100, shall set the upper saturation limit of dutyValue.
REQ-004 mhz_clk  input  1  shall be the single 25 MHz clock; all state updates on its rising edge.
REQ-005 reset  input  1  shall be the reset: synchronous, active-high.
REQ-006 btn_sel  input  1  shall be the raw asynchronous channel-select button, active-high.
REQ-007 btn_up  input  1  shall be the raw asynchronous increment button, active-high.
REQ-008 btn_down  input  1  shall be the raw asynchronous decrement button, active-high.
REQ-009 red_change  output  4  shall be the red level feeding horizontal_vertical_counter.
REQ-010 green_change  output  4  shall be the green level feeding horizontal_vertical_counter.
REQ-011 blue_change  output  4  shall be the blue level feeding horizontal_vertical_counter.
REQ-012 dutyValue  output  27  shall be the brightness duty value feeding horizontal_vertical_counter.
REQ-013 sel_channel  output  2  shall report the edited channel: 0 red, 1 green, 2 blue, 3 duty.

Function
REQ-014 Each button shall pass through a 2-flop synchronizer before any other logic.
REQ-015 Each button shall have its own debounce counter and stable flag; counter clears when synced level equals stable, else increments; when it reaches DEBOUNCE_CYCLES, stable takes the synced level and the counter clears in the same edge.
REQ-016 A press pulse shall be high for exactly one cycle, in the cycle after stable goes 0->1; release (1->0) shall produce no pulse.
REQ-017 Latency from the first edge sampling a new raw level to the press pulse shall be DEBOUNCE_CYCLES+3 cycles; bounce shorter than DEBOUNCE_CYCLES cycles shall produce no pulse.
REQ-018 Selection FSM states RED, GREEN, BLUE, DUTY; a sel pulse advances RED->GREEN->BLUE->DUTY->RED; sel_channel shall equal the state encoding.
REQ-019 An up pulse shall increment the selected channel by 1 (colors) or DUTY_STEP (duty), registered in the cycle after the pulse.
REQ-020 A down pulse shall decrement likewise.
REQ-021 Colors shall saturate at 4'h0 and 4'hF; no wrap-around.
REQ-022 dutyValue shall saturate: increment clamps to DUTY_MAX, decrement clamps to 0 when value < DUTY_STEP; arithmetic done at 28 bits.
REQ-023 Up and down pulses in the same cycle shall both be ignored.
REQ-024 A sel pulse coincident with up/down shall apply the adjustment to the currently selected (pre-advance) channel, then advance.
REQ-025 Unselected channels shall hold their values.
REQ-026 Outputs shall be driven directly from registers (no combinational path from inputs).

Reset
REQ-027 While reset is high at a clock edge: state RED, sel_channel 0, red/green/blue_change 4'hF, dutyValue 50, all synchronizer flops, stable flags and debounce counters 0, no pulses.
REQ-028 Reset asserted mid-debounce shall discard the partial count; a button still held after reset release shall be accepted as a new press after the full debounce latency.

Verification (DEBOUNCE_CYCLES=4, DUTY_STEP=10, DUTY_MAX=100)
REQ-029 Reset 2 cycles -> colors 4'hF, dutyValue 50, sel_channel 0.
REQ-030 btn_down held 10 cycles, released 10 cycles -> red_change 4'hE at cycle 8 after press (pulse at cycle 7 per REQ-017), green/blue unchanged.
REQ-031 btn_sel pressed 3 times, then btn_up 6 times -> sel_channel 3, dutyValue saturates at 100, colors unchanged.
REQ-032 btn_up toggled every 2 cycles for 20 cycles -> no pulse, all outputs unchanged.
REQ-033 btn_up and btn_down pressed together -> no change; btn_sel and btn_down together in RED with red 4'hF -> red 4'hE and sel_channel 1.
REQ-034 Reset pulsed at debounce count 2 while btn_up held -> after release of reset, exactly one increment after DEBOUNCE_CYCLES+3 cycles.

Source files
------------

// File: rtl/color_duty_ctrl.sv
// Colour/duty editor: three debounced buttons select a channel and
// nudge its level up or down with saturation.
module color_duty_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DUTY_STEP       = 10,
    parameter int DUTY_MAX        = 100
) (
    input  logic        mhz_clk,
    input  logic        reset,
    input  logic        btn_sel,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [3:0]  red_change,
    output logic [3:0]  green_change,
    output logic [3:0]  blue_change,
    output logic [26:0] dutyValue,
    output logic [1:0]  sel_channel
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES);
    localparam logic [27:0] STEP28 = 28'(DUTY_STEP);
    localparam logic [27:0] MAX28  = 28'(DUTY_MAX);
    localparam logic [26:0] DUTY_RST = 27'd50;

    localparam int B_SEL  = 0;
    localparam int B_UP   = 1;
    localparam int B_DOWN = 2;

    typedef enum logic [1:0] {
        ST_RED   = 2'd0,
        ST_GREEN = 2'd1,
        ST_BLUE  = 2'd2,
        ST_DUTY  = 2'd3
    } state_t;

    logic [2:0]    raw;
    logic [2:0]    sync1_q;
    logic [2:0]    sync2_q;
    logic [2:0]    stable_q;
    logic [2:0]    prev_q;
    logic [2:0]    press_q;
    logic [CW-1:0] cnt_q [3];

    assign raw = {btn_down, btn_up, btn_sel};

    // Synchronise, debounce, then register a one-cycle rising-edge pulse.
    always_ff @(posedge mhz_clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            press_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            prev_q  <= stable_q;
            press_q <= stable_q & ~prev_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_q[i] <= sync2_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    state_t      state_q;
    logic [3:0]  red_q;
    logic [3:0]  green_q;
    logic [3:0]  blue_q;
    logic [26:0] duty_q;

    logic        inc;
    logic        dec;
    logic [27:0] duty_ext;
    logic [27:0] duty_sum;
    logic [26:0] duty_d;

    assign inc = press_q[B_UP] & ~press_q[B_DOWN];
    assign dec = press_q[B_DOWN] & ~press_q[B_UP];

    function automatic logic [3:0] adj4(
        input logic [3:0] v,
        input logic       up,
        input logic       dn
    );
        logic [3:0] r;
        r = v;
        if (up && v != 4'hF) begin
            r = v + 4'd1;
        end else if (dn && v != 4'h0) begin
            r = v - 4'd1;
        end
        return r;
    endfunction

    always_comb begin
        duty_ext = {1'b0, duty_q};
        duty_sum = duty_ext + STEP28;
        duty_d   = duty_q;
        if (inc) begin
            duty_d = (duty_sum > MAX28) ? MAX28[26:0] : duty_sum[26:0];
        end else if (dec) begin
            duty_d = (duty_ext < STEP28) ? 27'd0 : 27'(duty_ext - STEP28);
        end
    end

    // Adjustment targets the pre-advance channel when sel coincides.
    always_ff @(posedge mhz_clk) begin
        if (reset) begin
            state_q <= ST_RED;
            red_q   <= 4'hF;
            green_q <= 4'hF;
            blue_q  <= 4'hF;
            duty_q  <= DUTY_RST;
        end else begin
            if (inc || dec) begin
                unique case (state_q)
                    ST_RED:   red_q   <= adj4(red_q, inc, dec);
                    ST_GREEN: green_q <= adj4(green_q, inc, dec);
                    ST_BLUE:  blue_q  <= adj4(blue_q, inc, dec);
                    ST_DUTY:  duty_q  <= duty_d;
                    default:  ;
                endcase
            end
            if (press_q[B_SEL]) begin
                unique case (state_q)
                    ST_RED:   state_q <= ST_GREEN;
                    ST_GREEN: state_q <= ST_BLUE;
                    ST_BLUE:  state_q <= ST_DUTY;
                    ST_DUTY:  state_q <= ST_RED;
                    default:  state_q <= ST_RED;
                endcase
            end
        end
    end

    assign red_change   = red_q;
    assign green_change = green_q;
    assign blue_change  = blue_q;
    assign dutyValue    = duty_q;
    assign sel_channel  = state_q;

endmodule

// File: tb/tb_color_duty_ctrl.sv
// Bench for color_duty_ctrl: directed scenarios plus random button
// activity compared every cycle against a behavioural model.
module tb_color_duty_ctrl;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bs = 1'b0;
    logic        bu = 1'b0;
    logic        bd = 1'b0;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic [26:0] duty;
    logic [1:0]  sel;

    always #5 clk = ~clk;

    color_duty_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .DUTY_STEP(10),
        .DUTY_MAX(100)
    ) dut (
        .mhz_clk(clk),
        .reset(rst),
        .btn_sel(bs),
        .btn_up(bu),
        .btn_down(bd),
        .red_change(red),
        .green_change(green),
        .blue_change(blue),
        .dutyValue(duty),
        .sel_channel(sel)
    );

    int tests = 0;
    int fails = 0;

    int m_col[3];
    int m_duty;
    int m_sel;
    int dl1[3];
    int dl2[3];
    int stab[3];
    int pend1[3];
    int pend2[3];
    int hist[3][$];

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        tests++;
        if (act !== 32'(exp)) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: a level is accepted once the synchronised sample has differed
    // from the accepted level on D+1 consecutive edges; the press takes
    // effect on the outputs two edges later.
    task automatic model_edge();
        int raw[3];
        int due[3];
        raw[0] = int'(bs);
        raw[1] = int'(bu);
        raw[2] = int'(bd);
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_col[i] = 15;
                dl1[i] = 0;
                dl2[i] = 0;
                stab[i] = 0;
                pend1[i] = 0;
                pend2[i] = 0;
                hist[i].delete();
            end
            m_duty = 50;
            m_sel = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                int acc;
                bit all_diff;
                due[i] = pend2[i];
                acc = 0;
                hist[i].push_back(dl2[i]);
                if (hist[i].size() > D + 1) void'(hist[i].pop_front());
                all_diff = (hist[i].size() == D + 1);
                foreach (hist[i][k]) if (hist[i][k] == stab[i]) all_diff = 0;
                if (all_diff) begin
                    stab[i] = dl2[i];
                    acc = stab[i];
                end
                pend2[i] = pend1[i];
                pend1[i] = acc;
                dl2[i] = dl1[i];
                dl1[i] = raw[i];
            end
            if (due[1] != due[2]) begin
                if (m_sel < 3) begin
                    if (due[1] == 1) m_col[m_sel] = (m_col[m_sel] < 15) ? m_col[m_sel] + 1 : 15;
                    else m_col[m_sel] = (m_col[m_sel] > 0) ? m_col[m_sel] - 1 : 0;
                end else begin
                    if (due[1] == 1) m_duty = (m_duty + 10 > 100) ? 100 : m_duty + 10;
                    else m_duty = (m_duty < 10) ? 0 : m_duty - 10;
                end
            end
            if (due[0] == 1) m_sel = (m_sel + 1) % 4;
        end
    endtask

    task automatic step(input logic s, input logic u, input logic d, input logic r);
        @(negedge clk);
        bs = s;
        bu = u;
        bd = d;
        rst = r;
        @(posedge clk);
        model_edge();
        #1;
        chk("red", 32'(red), m_col[0]);
        chk("green", 32'(green), m_col[1]);
        chk("blue", 32'(blue), m_col[2]);
        chk("duty", 32'(duty), m_duty);
        chk("sel", 32'(sel), m_sel);
    endtask

    task automatic press(input logic s, input logic u, input logic d);
        for (int k = 0; k < 9; k++) step(s, u, d, 1'b0);
        for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_red", 32'(red), 15);
        chk("rst_blue", 32'(blue), 15);
        chk("rst_duty", 32'(duty), 50);
        chk("rst_sel", 32'(sel), 0);

        for (int k = 0; k < 8; k++) step(0, 0, 1, 0);
        chk("down_early", 32'(red), 15);
        step(0, 0, 1, 0);
        chk("down_red", 32'(red), 14);
        chk("down_green", 32'(green), 15);
        step(0, 0, 1, 0);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
        chk("down_once", 32'(red), 14);

        for (int k = 0; k < 3; k++) press(1, 0, 0);
        for (int k = 0; k < 6; k++) press(0, 1, 0);
        chk("sat_sel", 32'(sel), 3);
        chk("sat_duty", 32'(duty), 100);
        chk("sat_red", 32'(red), 14);

        for (int k = 0; k < 20; k++) step(0, logic'((k / 2) % 2), 0, 0);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0);
        chk("bounce_duty", 32'(duty), 100);

        press(0, 1, 1);
        chk("both_duty", 32'(duty), 100);

        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        press(1, 0, 1);
        chk("seldn_red", 32'(red), 14);
        chk("seldn_sel", 32'(sel), 1);

        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        for (int k = 0; k < 8; k++) step(0, 0, 1, 0);
        chk("rstmid_early", 32'(red), 15);
        step(0, 0, 1, 0);
        chk("rstmid_red", 32'(red), 14);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
        chk("rstmid_once", 32'(red), 14);

        for (int n = 0; n < 600; n++) begin
            int pat;
            int len;
            pat = int'($urandom_range(0, 7));
            len = int'($urandom_range(1, 12));
            for (int k = 0; k < len; k++) begin
                step(logic'(pat[0]), logic'(pat[1]), logic'(pat[2]),
                     logic'($urandom_range(0, 199) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
